// File: rtl/swarm_runtime_cfg.sv
// swarm_runtime_cfg
//   Host-writable, double-buffered runtime configuration block. Host writes
//   land in a shadow bank. A commit command copies the shadow bank into the
//   active bank once the task system reports quiesce. The active bank then
//   reaches every tile through a PIPE_STAGES-deep register pipeline, and
//   commit_done pulses when the tile outputs hold the new values.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no commit outstanding
//   WAIT_Q | commit requested, waiting for quiesce to copy shadow->active
//   DIST   | active bank copied, counting down the pipeline latency
//
// Ports
//   clk, rstn                       clock, async active-low reset
//   reg_wvalid/wready/waddr/wdata   host write channel
//   reg_rreq/raddr                  host read request (always accepted)
//   reg_rresp_valid/data            read response, one cycle after rreq
//   quiesce                         task system idle, commit may proceed
//   commit_pending                  commit waiting for quiesce or distributing
//   commit_done                     one-cycle pulse, tiles hold new values
//   cfg_epoch                       completed commit count (wraps)
//   tile_cfg                        per-tile copy of the active bank
//
// Address map
//   0x00..N_REGS-1  shadow bank (rw)
//   0x80|i          active bank (ro)
//   0xFE            status (ro): {cfg_epoch, err, commit_pending}
//   0xFF            command (wo): bit0 commit, bit1 revert (revert wins)
module swarm_runtime_cfg #(
    parameter int N_TILES     = 1,
    parameter int N_REGS      = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter logic [N_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  reg_wvalid,
    output logic                                  reg_wready,
    input  logic [7:0]                            reg_waddr,
    input  logic [DATA_WIDTH-1:0]                 reg_wdata,
    input  logic                                  reg_rreq,
    input  logic [7:0]                            reg_raddr,
    output logic                                  reg_rresp_valid,
    output logic [DATA_WIDTH-1:0]                 reg_rresp_data,
    input  logic                                  quiesce,
    output logic                                  commit_pending,
    output logic                                  commit_done,
    output logic [7:0]                            cfg_epoch,
    output logic [N_TILES*N_REGS*DATA_WIDTH-1:0]  tile_cfg
);

    localparam int          BANK_W      = N_REGS * DATA_WIDTH;
    localparam logic [7:0]  ADDR_STATUS = 8'hFE;
    localparam logic [7:0]  ADDR_CMD    = 8'hFF;
    localparam logic [8:0]  N_REGS_L    = 9'(N_REGS);
    localparam logic [3:0]  PIPE_CNT    = 4'(PIPE_STAGES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Q = 2'd1,
        DIST   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q;
    logic [BANK_W-1:0]      shadow_q;
    logic [BANK_W-1:0]      active_q;
    logic [BANK_W-1:0]      pipe_out;
    logic [7:0]             epoch_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  rdata_d;

    logic wr_acc, cmd_wr, cmd_commit, cmd_revert, shadow_hit, wr_illegal;
    logic copy_en, revert_en, done;

    // ---------------------------------------------------------------
    // Write decode
    // ---------------------------------------------------------------
    assign reg_wready = (state_q != DIST);
    assign wr_acc     = reg_wvalid & reg_wready;
    assign shadow_hit = ({1'b0, reg_waddr} < N_REGS_L);
    assign cmd_wr     = wr_acc & (reg_waddr == ADDR_CMD);
    assign cmd_revert = cmd_wr & reg_wdata[1];
    assign cmd_commit = cmd_wr & reg_wdata[0] & ~reg_wdata[1];
    // Active-bank and status addresses are read-only; writes there are
    // dropped and flagged just like writes to unmapped space.
    assign wr_illegal = wr_acc & ~shadow_hit & (reg_waddr != ADDR_CMD);

    // ---------------------------------------------------------------
    // Commit FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            epoch_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (copy_en)
                cnt_q <= PIPE_CNT;
            else if (state_q == DIST && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (done)
                epoch_q <= epoch_q + 8'd1;
            if (wr_illegal)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        copy_en   = 1'b0;
        revert_en = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_revert)
                    revert_en = 1'b1;
                else if (cmd_commit)
                    state_d = WAIT_Q;
            end
            WAIT_Q: begin
                // A revert cancels the commit even if quiesce is high.
                if (cmd_revert) begin
                    revert_en = 1'b1;
                    state_d   = IDLE;
                end else if (quiesce) begin
                    copy_en = 1'b1;
                    state_d = DIST;
                end
            end
            DIST: begin
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit_pending = (state_q != IDLE);
    assign commit_done    = done;
    assign cfg_epoch      = epoch_q;

    // ---------------------------------------------------------------
    // Shadow and active banks. The copy reads the pre-edge shadow, so a
    // shadow write accepted in the copy cycle lands after the copy.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= RESET_VALS;
            active_q <= RESET_VALS;
        end else begin
            if (copy_en)
                active_q <= shadow_q;
            if (revert_en)
                shadow_q <= active_q;
            else if (wr_acc && shadow_hit) begin
                for (int i = 0; i < N_REGS; i++) begin
                    if (reg_waddr == 8'(i))
                        shadow_q[i*DATA_WIDTH +: DATA_WIDTH] <= reg_wdata;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path: registered, one cycle latency, pre-edge values.
    // ---------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (reg_raddr == 8'(i))
                rdata_d = shadow_q[i*DATA_WIDTH +: DATA_WIDTH];
            if (reg_raddr == (8'h80 | 8'(i)))
                rdata_d = active_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (reg_raddr == ADDR_STATUS)
            rdata_d = DATA_WIDTH'({epoch_q, err_q, commit_pending});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_rresp_valid <= 1'b0;
            reg_rresp_data  <= '0;
        end else begin
            reg_rresp_valid <= reg_rreq;
            reg_rresp_data  <= reg_rreq ? rdata_d : '0;
        end
    end

    // ---------------------------------------------------------------
    // Distribution: one shared pipe fanned out to every tile.
    // ---------------------------------------------------------------
    generate
        if (PIPE_STAGES == 0) begin : g_nopipe
            assign pipe_out = active_q;
        end else begin : g_pipe
            logic [BANK_W-1:0] stage_q [PIPE_STAGES];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < PIPE_STAGES; s++)
                        stage_q[s] <= RESET_VALS;
                end else begin
                    stage_q[0] <= active_q;
                    for (int s = 1; s < PIPE_STAGES; s++)
                        stage_q[s] <= stage_q[s-1];
                end
            end

            assign pipe_out = stage_q[PIPE_STAGES-1];
        end
    endgenerate

    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        assign tile_cfg[t*BANK_W +: BANK_W] = pipe_out;
    end

endmodule

// File: tb/tb_swarm_runtime_cfg.sv
// Bench for swarm_runtime_cfg: a behavioural model of the register block
// (arrays of register values plus a commit timestamp) is compared against
// the DUT every cycle, alongside directed literal checks.
module tb_swarm_runtime_cfg;

    localparam int NT = 2;
    localparam int NR = 16;
    localparam int DW = 32;
    localparam int P  = 2;

    function automatic logic [NR*DW-1:0] build_rv();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++)
            r[i*DW +: DW] = 32'hA500_0000 | 32'(i);
        return r;
    endfunction

    localparam logic [NR*DW-1:0] RV = build_rv();

    logic               clk;
    logic               rstn;
    logic               reg_wvalid;
    logic               reg_wready;
    logic [7:0]         reg_waddr;
    logic [DW-1:0]      reg_wdata;
    logic               reg_rreq;
    logic [7:0]         reg_raddr;
    logic               reg_rresp_valid;
    logic [DW-1:0]      reg_rresp_data;
    logic               quiesce;
    logic               commit_pending;
    logic               commit_done;
    logic [7:0]         cfg_epoch;
    logic [NT*NR*DW-1:0] tile_cfg;

    swarm_runtime_cfg #(
        .N_TILES(NT), .N_REGS(NR), .DATA_WIDTH(DW), .PIPE_STAGES(P),
        .RESET_VALS(RV)
    ) dut (
        .clk(clk), .rstn(rstn),
        .reg_wvalid(reg_wvalid), .reg_wready(reg_wready),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_rreq(reg_rreq), .reg_raddr(reg_raddr),
        .reg_rresp_valid(reg_rresp_valid), .reg_rresp_data(reg_rresp_data),
        .quiesce(quiesce), .commit_pending(commit_pending),
        .commit_done(commit_done), .cfg_epoch(cfg_epoch),
        .tile_cfg(tile_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_shadow [NR];
    logic [31:0] m_active [NR];
    logic [31:0] m_hist   [P+1][NR];   // m_hist[k] = active bank k cycles ago
    logic [31:0] os [NR];
    logic [31:0] oa [NR];
    bit          m_pend, m_dist, m_err, m_rvalid;
    logic [7:0]  m_epoch;
    logic [31:0] m_rdata;
    int          cyc, m_done_at;

    function automatic logic [31:0] rd_model(input logic [7:0] a);
        if (a < 8'(NR))                          return m_shadow[a[3:0]];
        if (a >= 8'h80 && a < 8'(8'h80 + NR))    return m_active[a[3:0]];
        if (a == 8'hFE)                          return {22'd0, m_epoch, m_err, m_pend};
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = RV[i*DW +: DW];
            m_active[i] = RV[i*DW +: DW];
            for (int k = 0; k <= P; k++) m_hist[k][i] = RV[i*DW +: DW];
        end
        m_pend = 0; m_dist = 0; m_err = 0; m_rvalid = 0; m_rdata = 0;
        m_epoch = 0; m_done_at = -1;
    endtask

    task automatic model_step();
        bit acc;
        acc = reg_wvalid && !m_dist;
        os  = m_shadow;
        oa  = m_active;
        m_rvalid = reg_rreq;
        m_rdata  = rd_model(reg_raddr);
        if (m_dist) begin
            if (cyc == m_done_at) begin
                m_dist = 0; m_pend = 0; m_epoch = m_epoch + 8'd1;
            end
        end else if (m_pend) begin
            if (acc && reg_waddr == 8'hFF && reg_wdata[1])
                m_pend = 0;
            else if (quiesce) begin
                m_active  = os;
                m_dist    = 1;
                m_done_at = cyc + 1 + P;
            end
        end else if (acc && reg_waddr == 8'hFF && reg_wdata[1:0] == 2'b01) begin
            m_pend = 1;
        end
        if (acc) begin
            if (reg_waddr < 8'(NR))      m_shadow[reg_waddr[3:0]] = reg_wdata;
            else if (reg_waddr == 8'hFF) begin
                if (reg_wdata[1]) m_shadow = oa;
            end else                     m_err = 1;
        end
        for (int k = P; k >= 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_active;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                model_reset();
                cyc = 0;
            end else begin
                model_step();
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("wready",  {31'd0, reg_wready},      {31'd0, !m_dist});
            chk("pending", {31'd0, commit_pending},  {31'd0, m_pend});
            chk("done",    {31'd0, commit_done},     {31'd0, (m_dist && cyc == m_done_at)});
            chk("epoch",   {24'd0, cfg_epoch},       {24'd0, m_epoch});
            chk("rvalid",  {31'd0, reg_rresp_valid}, {31'd0, m_rvalid});
            if (m_rvalid) chk("rdata", reg_rresp_data, m_rdata);
            for (int t = 0; t < NT; t++)
                for (int i = 0; i < NR; i++)
                    chk("tile_cfg", tile_cfg[(t*NR+i)*DW +: DW], m_hist[P][i]);
            if (commit_done) done_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wvalid = 1'b1; reg_waddr = a; reg_wdata = d;
        tick();
        reg_wvalid = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
        reg_rreq = 1'b1; reg_raddr = a;
        tick();
        reg_rreq = 1'b0;
        chk({nm, "_valid"}, {31'd0, reg_rresp_valid}, 32'd1);
        chk(nm, reg_rresp_data, exp);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!commit_done && n < 40) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, commit_done}, 32'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int seen;
        rstn = 1'b0; reg_wvalid = 1'b0; reg_waddr = '0; reg_wdata = '0;
        reg_rreq = 1'b0; reg_raddr = '0; quiesce = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // reset state
        chk("rst_wready", {31'd0, reg_wready}, 32'd1);
        chk("rst_rvalid", {31'd0, reg_rresp_valid}, 32'd0);
        chk("rst_rdata", reg_rresp_data, 32'd0);
        chk("rst_tile0_r5", tile_cfg[5*DW +: DW], 32'hA500_0005);
        chk("rst_tile1_r15", tile_cfg[(NR+15)*DW +: DW], 32'hA500_000F);
        rd("rst_rd00", 8'h00, 32'hA500_0000);
        rd("rst_status", 8'hFE, 32'd0);

        // basic commit, quiesce high, exact latency
        quiesce = 1'b1;
        wr(8'h03, 32'hDEAD_BEEF);
        rd("sh03", 8'h03, 32'hDEAD_BEEF);
        wr(8'hFF, 32'd1);                          // now cycle t+1
        chk("t1_pending", {31'd0, commit_pending}, 32'd1);
        tick();                                    // t+2
        rd("act83", 8'h83, 32'hDEAD_BEEF);         // issued t+2, now t+3
        chk("t3_done", {31'd0, commit_done}, 32'd0);
        chk("t3_tile_old", tile_cfg[3*DW +: DW], 32'hA500_0003);
        tick();                                    // t+4
        chk("t4_done", {31'd0, commit_done}, 32'd1);
        chk("t4_tile0_r3", tile_cfg[3*DW +: DW], 32'hDEAD_BEEF);
        chk("t4_tile1_r3", tile_cfg[(NR+3)*DW +: DW], 32'hDEAD_BEEF);
        tick();
        chk("epoch1", {24'd0, cfg_epoch}, 32'd1);
        chk("t5_pending", {31'd0, commit_pending}, 32'd0);

        // commit held off by quiesce, write during wait, same-cycle write at copy
        quiesce = 1'b0;
        wr(8'hFF, 32'd1);
        for (int k = 0; k < 50; k++) begin
            if (k == 20) begin reg_wvalid = 1'b1; reg_waddr = 8'h01; reg_wdata = 32'h5; end
            tick();
            reg_wvalid = 1'b0;
            chk("wait_pending", {31'd0, commit_pending}, 32'd1);
        end
        quiesce = 1'b1; reg_wvalid = 1'b1; reg_waddr = 8'h02; reg_wdata = 32'h22;
        tick();
        reg_wvalid = 1'b0;
        chk("dist_wready", {31'd0, reg_wready}, 32'd0);
        wait_done("t3_done_seen");
        rd("act81", 8'h81, 32'h5);
        rd("act82_old", 8'h82, 32'hA500_0002);
        rd("sh02_new", 8'h02, 32'h22);
        chk("epoch2", {24'd0, cfg_epoch}, 32'd2);

        // revert cancels a pending commit
        quiesce = 1'b0;
        wr(8'h05, 32'h1234);
        wr(8'hFF, 32'd1);
        repeat (3) tick();
        wr(8'hFF, 32'd2);
        chk("rev_pending", {31'd0, commit_pending}, 32'd0);
        seen = done_seen;
        repeat (10) tick();
        chk("rev_no_done", 32'(done_seen), 32'(seen));
        quiesce = 1'b1;
        rd("rev_sh02", 8'h02, 32'hA500_0002);
        rd("rev_sh05", 8'h05, 32'hA500_0005);
        rd("rev_sh03", 8'h03, 32'hDEAD_BEEF);
        chk("rev_epoch", {24'd0, cfg_epoch}, 32'd2);

        // illegal write
        wr(8'h40, 32'h77);
        rd("err_status", 8'hFE, 32'h0000_000A);
        rd("err_sh00", 8'h00, 32'hA500_0000);
        rd("unmapped40", 8'h40, 32'd0);
        wr(8'h85, 32'h99);
        rd("ro_act85", 8'h85, 32'hA500_0005);

        // epoch wrap
        for (int k = 0; k < 253; k++) begin
            wr(8'hFF, 32'd1);
            wait_done("wrap_done");
        end
        chk("epoch255", {24'd0, cfg_epoch}, 32'd255);
        rd("status255", 8'hFE, 32'h0000_03FE);
        wr(8'hFF, 32'd1);
        wait_done("wrap_last_done");
        chk("epoch_wrap0", {24'd0, cfg_epoch}, 32'd0);
        rd("status_wrap", 8'hFE, 32'h0000_0002);

        // reset during distribution
        wr(8'h07, 32'hCAFE_0007);
        wr(8'hFF, 32'd1);
        tick();                                    // in DIST
        chk("pre_rst_wready", {31'd0, reg_wready}, 32'd0);
        seen = done_seen;
        rstn = 1'b0;
        #1;
        chk("ar_pending", {31'd0, commit_pending}, 32'd0);
        chk("ar_done", {31'd0, commit_done}, 32'd0);
        chk("ar_wready", {31'd0, reg_wready}, 32'd1);
        chk("ar_epoch", {24'd0, cfg_epoch}, 32'd0);
        chk("ar_tile_r3", tile_cfg[3*DW +: DW], 32'hA500_0003);
        chk("ar_tile_r7", tile_cfg[(NR+7)*DW +: DW], 32'hA500_0007);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (6) tick();
        chk("ar_no_done", 32'(done_seen), 32'(seen));
        rd("ar_sh07", 8'h07, 32'hA500_0007);
        rd("ar_act87", 8'h87, 32'hA500_0007);
        rd("ar_status", 8'hFE, 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swarm_runtime_cfg.md
# swarm_runtime_cfg

Runtime configuration register block: a host-writable, double-buffered register file that replaces compile-time-only knobs (logging/stats tile masks, GVT period, spill thresholds) with values that can change between runs. It sits behind the OCL slave of tile 0. Host writes land in a shadow bank, and a commit command copies them into an active bank, but only while the task system reports quiescence. The active values are then distributed to all tiles through a configurable register pipeline, and completion is signalled back to the host.

## Interface
- N_TILES, 1: number of tile copies of the active bank.
- N_REGS, 16: number of 32-bit config registers; 1..64.
- DATA_WIDTH, 32: register width.
- PIPE_STAGES, 2: distribution pipeline depth to tiles; 0..8.
- RESET_VALS, all zeros: flat N_REGS*DATA_WIDTH vector; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- clk  in  1  clock; the single clock for the block.
- rstn  in  1  asynchronous, active-low reset.
- reg_wvalid  in  1  host write request.
- reg_wready  out  1  write accepted when wvalid&wready.
- reg_waddr  in  8  write address.
- reg_wdata  in  DATA_WIDTH  write data.
- reg_rreq  in  1  read request; always accepted.
- reg_raddr  in  8  read address.
- reg_rresp_valid  out  1  read data valid.
- reg_rresp_data  out  DATA_WIDTH  read data.
- quiesce  in  1  task system idle; commit permitted.
- commit_pending  out  1  a commit is waiting for quiesce or still distributing.
- commit_done  out  1  one-cycle pulse once tile outputs hold the new values.
- cfg_epoch  out  8  count of completed commits; wraps.
- tile_cfg  out  N_TILES*N_REGS*DATA_WIDTH  per-tile active configuration.

## Operation
- Address map:
  - 0x00..N_REGS-1: shadow bank, read/write.
  - 0x80|i: active bank i, read-only.
  - 0xFE: status, read-only. Read data is {cfg_epoch[7:0], err, commit_pending} in bits [9:0], zero above.
  - 0xFF: command, write-only.
    - wdata[0]=1: commit.
    - wdata[1]=1: revert, shadow←active.
    - Both bits set: revert wins.
- Illegal accesses:
  - A write to any other address, or to 0x80..0xFE, is accepted and dropped, and sets the sticky err bit.
  - err clears only on reset.
  - A read of an unmapped address returns 0.
- FSM states: IDLE, WAIT_Q, DIST.
  - IDLE, commit cmd → WAIT_Q; commit_pending=1.
  - WAIT_Q:
    - Shadow writes are still accepted.
    - Revert cmd cancels the commit and → IDLE.
    - A repeated commit cmd is ignored.
    - On a cycle with quiesce=1, active←shadow (shadow value including any write accepted that same cycle is NOT included; that write lands after the copy), a counter is loaded with PIPE_STAGES, and the FSM → DIST.
  - DIST:
    - reg_wready=0.
    - The counter decrements each cycle; at 0, commit_done pulses, cfg_epoch increments, commit_pending drops, and the FSM → IDLE.
- Distribution:
  - The active bank feeds PIPE_STAGES register stages, replicated per tile or fanned from a shared pipe (implementer's choice).
  - tile_cfg equals the active bank delayed exactly PIPE_STAGES cycles.
  - PIPE_STAGES=0: tile_cfg is the active bank combinationally.
- Quiesce dropping after the copy does not abort distribution.

## Timing
- Write: accepted at edge t; the shadow value is visible to a read issued at t+1.
- Read: rreq at edge t gives rresp_valid=1 and data at t+1, for one cycle. Back-to-back reads are allowed each cycle.
- Read and write to the same address in the same cycle: the read returns the old value.
- Commit latency, with quiesce already high:
  - Command accepted at t: WAIT_Q at t+1, active copied at t+1, DIST from t+2.
  - commit_done at t+2+PIPE_STAGES.
  - tile_cfg is new from that same cycle.
- Reset values:
  - shadow = active = all pipe stages = RESET_VALS; tile_cfg = RESET_VALS.
  - FSM in IDLE; reg_wready=1; reg_rresp_valid=0; reg_rresp_data=0.
  - commit_pending=0; commit_done=0; cfg_epoch=0; err=0.
- Reset asserted mid-commit returns everything to the reset values immediately (async); no commit_done is produced.
- cfg_epoch wraps 255→0.

## Test plan
- After reset: reading 0x00 returns RESET_VALS[0]; reading 0xFE returns 0; every tile_cfg slice equals RESET_VALS.
- Write 0x03=0xDEADBEEF, then commit with quiesce=1 and PIPE_STAGES=2 (command at t): active 0x83 reads 0xDEADBEEF from t+2; commit_done at t+4 exactly; tile_cfg reg 3 is 0xDEADBEEF on all tiles; epoch=1.
- Commit with quiesce=0 for 50 cycles, writing 0x01=0x5 during the wait, then quiesce=1: commit_pending stays high throughout; the committed active[1]=0x5; reg_wready=0 during DIST only.
- Pending commit followed by a revert command: commit_pending→0; no commit_done; shadow equals the prior active values; epoch unchanged.
- Write to 0x40 (N_REGS=16): err=1 in status; no register changes; the next read of 0xFE shows bit1 set.
- 256 commits: epoch wraps to 0. Reset asserted during DIST: outputs at reset values, with no commit_done pulse.
